// File: rtl/piso_serializer.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define PISO_SERIALIZER_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module piso_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int SUB_W = ($clog2(CLKS_PER_BIT + 1) < 1) ? 1 : $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef PISO_SERIALIZER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [SUB_W-1:0] sub_cnt_r, sub_cnt_s;
    logic             period_end_s;
    logic             q_r, ready_r, busy_r, done_r;
    logic             q_s, ready_s, busy_s, done_s;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_r, par_s;
`endif

    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // State, datapath and registered outputs; reset wins over any load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            sub_cnt_r <= '0;
            q_r       <= 1'b1;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            sub_cnt_r <= sub_cnt_s;
            q_r       <= q_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_r     <= par_s;
`endif
        end
    end

    // Next-state and datapath update; every non-idle state lasts one full bit period.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        bit_cnt_s    = bit_cnt_r;
        sub_cnt_s    = sub_cnt_r;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_s        = par_r;
`endif
        period_end_s = (sub_cnt_r == SUB_LAST);
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_s   = ST_START;
                    shift_s   = din;
                    bit_cnt_s = '0;
                    sub_cnt_s = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
                    par_s     = even_parity(din);
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (period_end_s) begin
                    state_s   = ST_DATA;
                    sub_cnt_s = '0;
                end else begin
                    sub_cnt_s = sub_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (period_end_s) begin
                    sub_cnt_s = '0;
                    shift_s   = shift_r >> 1'b1;
                    bit_cnt_s = bit_cnt_r + 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    sub_cnt_s = sub_cnt_r + 1'b1;
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (period_end_s) begin
                    state_s   = ST_STOP;
                    sub_cnt_s = '0;
                end else begin
                    sub_cnt_s = sub_cnt_r + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (period_end_s) begin
                    state_s   = ST_IDLE;
                    sub_cnt_s = '0;
                end else begin
                    sub_cnt_s = sub_cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        q_s     = 1'b1;
        ready_s = 1'b0;
        busy_s  = 1'b1;
        case (state_s)
            ST_IDLE: begin
                q_s     = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            ST_START:  q_s = 1'b0;
            ST_DATA:   q_s = shift_s[0];
`ifdef PISO_SERIALIZER_PARITY_EN
            ST_PARITY: q_s = par_s;
`endif
            ST_STOP:   q_s = 1'b1;
            default: begin
                q_s     = 1'b1;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
        if ((state_r == ST_STOP) && (state_s == ST_IDLE)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    assign q     = q_r;
    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
